// File: rtl/uart_word_tx_serializer.sv
// Serializes one accepted multi-byte word into a sequence of UART TX byte requests,
// waiting for the transmitter's busy handshake (or an ack timeout) between bytes.
module uart_word_tx_serializer #(
  parameter int WORD_BYTES  = 8,
  parameter int MSB_FIRST   = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_en,
  input  logic                    uart_tx_busy,
  output logic                    word_done,
  output logic                    ack_err
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
  logic [WORD_W-1:0] shift_reg, shift_d;
  logic [TMR_W-1:0]  ack_tmr, ack_tmr_d;
  logic [7:0]        tx_data_d;
  logic              tx_en_d, done_d, err_d, finish_byte;

  function automatic logic [7:0] cur_byte(input logic [WORD_W-1:0] s);
    if (MSB_FIRST != 0) return s[WORD_W-1 -: 8];
    else                return s[7:0];
  endfunction

  function automatic logic [WORD_W-1:0] next_shift(input logic [WORD_W-1:0] s);
    if (MSB_FIRST != 0) return s << 8;
    else                return s >> 8;
  endfunction

  assign word_ready = (state == IDLE);

  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    shift_d     = shift_reg;
    ack_tmr_d   = ack_tmr;
    tx_data_d   = uart_tx_data;
    tx_en_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = ack_err;
    finish_byte = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid) begin
          shift_d    = word_in;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!uart_tx_busy) begin
          tx_data_d = cur_byte(shift_reg);
          tx_en_d   = 1'b1;
          ack_tmr_d = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if ((ack_tmr + TMR_W'(1)) == TMR_LIMIT) begin
          // No response from the transmitter: flag it and move on as if sent.
          err_d       = 1'b1;
          finish_byte = 1'b1;
        end else begin
          ack_tmr_d = ack_tmr + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) finish_byte = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (finish_byte) begin
      if (byte_cnt == LAST_BYTE) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        shift_d    = next_shift(shift_reg);
        byte_cnt_d = byte_cnt + CNT_W'(1);
        state_d    = SEND;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      shift_reg    <= '0;
      ack_tmr      <= '0;
      uart_tx_data <= '0;
      uart_tx_en   <= 1'b0;
      word_done    <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_d;
      byte_cnt     <= byte_cnt_d;
      shift_reg    <= shift_d;
      ack_tmr      <= ack_tmr_d;
      uart_tx_data <= tx_data_d;
      uart_tx_en   <= tx_en_d;
      word_done    <= done_d;
      ack_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx_serializer.sv
// Randomized scoreboard bench: an MSB-first and an LSB-first serializer share one
// stimulus stream and one behavioural UART transmitter model.
module tb_uart_word_tx_serializer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] word_in;
  logic        word_valid;
  logic        uart_tx_busy;
  logic        ready_m, en_m, done_m, err_m;
  logic        ready_l, en_l, done_l, err_l;
  logic [7:0]  data_m, data_l;

  int checks = 0;
  int failures = 0;

  // transmitter model controls
  bit never_ack  = 0;
  bit force_busy = 0;
  int busy_len   = 10;
  bit start_pend = 0;
  int busy_left  = 0;

  // scoreboard
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  bit         exp_err_q[$];
  int         en_total = 0;
  int         done_total = 0;
  int         bytes_in_word = 0;
  logic [7:0] last_data = 8'h00;
  bit         prev_en = 0;

  uart_word_tx_serializer #(.WORD_BYTES(8), .MSB_FIRST(1), .ACK_TIMEOUT(16)) u_msb (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready_m), .uart_tx_data(data_m), .uart_tx_en(en_m),
    .uart_tx_busy(uart_tx_busy), .word_done(done_m), .ack_err(err_m));

  uart_word_tx_serializer #(.WORD_BYTES(8), .MSB_FIRST(0), .ACK_TIMEOUT(16)) u_lsb (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready_l), .uart_tx_data(data_l), .uart_tx_en(en_l),
    .uart_tx_busy(uart_tx_busy), .word_done(done_l), .ack_err(err_l));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // UART transmitter: busy rises the cycle after en and stays high busy_len cycles.
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_pend) begin
        start_pend = 0;
        busy_left  = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (en_m && !never_ack) start_pend = 1;
      uart_tx_busy = force_busy || (busy_left > 0);
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!resetn) begin
      bytes_in_word = 0;
      last_data     = 8'h00;
      prev_en       = 0;
    end else begin
      if (en_m) begin
        check("en_pair", en_l, 1'b1);
        check("en_single_cycle", prev_en, 1'b0);
        check("en_while_busy_forced", force_busy, 1'b0);
        if (exp_m_q.size() == 0) begin
          check("unexpected_en", 1'b1, 1'b0);
        end else begin
          check("byte_msb_first", data_m, exp_m_q.pop_front());
          check("byte_lsb_first", data_l, exp_l_q.pop_front());
        end
        en_total++;
        bytes_in_word++;
        last_data = data_m;
      end else begin
        check("data_hold", data_m, last_data);
      end
      if (done_m) begin
        check("done_pair", done_l, 1'b1);
        if (exp_err_q.size() == 0) begin
          check("unexpected_word_done", 1'b1, 1'b0);
        end else begin
          bit e;
          e = exp_err_q.pop_front();
          check("ack_err_at_done_msb", err_m, e);
          check("ack_err_at_done_lsb", err_l, e);
        end
        check("bytes_per_word", bytes_in_word, 8);
        bytes_in_word = 0;
        done_total++;
      end
      prev_en = en_m;
    end
  end

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int idx);
    return 8'((w >> (8 * idx)) & 64'hFF);
  endfunction

  task automatic send_word(input logic [63:0] w, input bit keep_valid,
                           input bit chk_b2b, input bit chk_lat);
    int n;
    word_in    = w;
    word_valid = 1'b1;
    n = 0;
    while (!ready_m && n < 3000) begin
      step();
      n++;
    end
    if (!ready_m) begin
      check("accept_timeout", 1'b0, 1'b1);
      word_valid = 1'b0;
      return;
    end
    if (chk_b2b) check("b2b_accept_on_done_edge", done_m, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_m_q.push_back(byte_of(w, 7 - i));
      exp_l_q.push_back(byte_of(w, i));
    end
    exp_err_q.push_back(never_ack);
    step();
    if (!keep_valid) word_valid = 1'b0;
    check("ack_err_cleared_on_accept", err_m, 1'b0);
    check("not_ready_after_accept", ready_m, 1'b0);
    if (chk_lat && !uart_tx_busy) begin
      step();
      check("first_en_latency", en_m, 1'b1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_m_q.size() != 0 || exp_err_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    if (exp_m_q.size() != 0 || exp_err_q.size() != 0) check("drain_timeout", 1'b0, 1'b1);
    repeat (3) step();
  endtask

  initial begin
    int base;
    int n;
    resetn     = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    repeat (3) step();
    check("reset_data", data_m, 8'h00);
    check("reset_en", en_m, 1'b0);
    check("reset_done", done_m, 1'b0);
    check("reset_err", err_m, 1'b0);
    check("reset_ready", ready_m, 1'b1);
    resetn = 1'b1;
    step();

    // Known word, both byte orders
    send_word(64'h0123_4567_89AB_CDEF, 0, 0, 1);
    drain();

    // Back-to-back words with one-cycle busy
    busy_len = 1;
    base = en_total;
    send_word({$urandom, $urandom}, 1, 0, 1);
    send_word({$urandom, $urandom}, 0, 1, 0);
    drain();
    check("b2b_en_count", en_total - base, 16);

    // Transmitter never responds
    never_ack = 1;
    base = done_total;
    send_word({$urandom, $urandom}, 0, 0, 1);
    drain();
    check("timeout_word_done", done_total - base, 1);
    check("ack_err_sticky", err_m, 1'b1);
    never_ack = 0;
    busy_len  = 4;
    send_word({$urandom, $urandom}, 0, 0, 1);
    drain();

    // Busy held by another user at acceptance
    force_busy = 1;
    busy_len   = 10;
    step();
    step();
    base = en_total;
    send_word({$urandom, $urandom}, 0, 0, 0);
    repeat (20) step();
    check("no_en_while_busy", en_total - base, 0);
    force_busy = 0;
    drain();
    check("en_after_busy_release", en_total - base, 8);

    // Reset in the middle of a word
    busy_len = 3;
    base = en_total;
    send_word(64'hFEDC_BA98_7654_3210, 0, 0, 1);
    n = 0;
    while (en_total < base + 3 && n < 1000) begin
      step();
      n++;
    end
    check("third_en_seen", en_total - base, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_reset_data", data_m, 8'h00);
    check("mid_reset_en", en_m, 1'b0);
    check("mid_reset_done", done_m, 1'b0);
    check("mid_reset_err", err_m, 1'b0);
    check("mid_reset_ready", ready_m, 1'b1);
    exp_m_q.delete();
    exp_l_q.delete();
    exp_err_q.delete();
    step();
    step();
    resetn = 1'b1;
    repeat (15) step();
    check("no_en_after_reset", en_total - base, 3);
    base = en_total;
    send_word({$urandom, $urandom}, 0, 0, 1);
    drain();
    check("full_word_after_reset", en_total - base, 8);

    // Random words and transmitter timing
    for (int k = 0; k < 6; k++) begin
      busy_len = int'($urandom_range(1, 10));
      send_word({$urandom, $urandom}, 0, 0, 1);
      drain();
    end

    check("scoreboard_empty", exp_m_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
